// File: rtl/systolic_operand_feeder.sv
`default_nettype none
// ============================================================================
// Module   : systolic_operand_feeder
// Purpose  : Skews K-step A-column / B-row operand vectors into a diagonal
//            wavefront for an output-stationary systolic array.  It also
//            sequences the enable, clear_acc and compute_enable controls for
//            one tile pass: clear, feed, drain, done.
// Revision : 1.0 - initial release
// ============================================================================
module systolic_operand_feeder #(
  parameter int DATA_BITS  = 16,
  parameter int ARRAY_SIZE = 8,
  parameter int K_BITS     = 8
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic                            start_i,
  input  logic [K_BITS-1:0]               k_len_i,
  input  logic                            in_valid_i,
  output logic                            in_ready_o,
  input  logic [ARRAY_SIZE*DATA_BITS-1:0] a_vec_i,
  input  logic [ARRAY_SIZE*DATA_BITS-1:0] b_vec_i,
  output logic                            arr_enable_o,
  output logic                            clear_acc_o,
  output logic                            compute_enable_o,
  output logic [ARRAY_SIZE*DATA_BITS-1:0] a_inputs_o,
  output logic [ARRAY_SIZE*DATA_BITS-1:0] b_inputs_o,
  output logic                            busy_o,
  output logic                            done_o
);

  // The wavefront needs 2*(N-1) zero-injecting cycles to leave the array.
  localparam int DRAIN_CYCLES = 2 * (ARRAY_SIZE - 1);
  localparam int DRAIN_BITS   = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DRAIN_BITS-1:0] DRAIN_LAST =
      DRAIN_BITS'((DRAIN_CYCLES > 0) ? (DRAIN_CYCLES - 1) : 0);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_FEED  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [K_BITS-1:0]     k_len_q, k_len_d;
  logic [K_BITS-1:0]     step_q, step_d;
  logic [DRAIN_BITS-1:0] drain_q, drain_d;
  logic                  transfer;

  // State register, latched pass length and the step/drain counters.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      k_len_q <= '0;
      step_q  <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      k_len_q <= k_len_d;
      step_q  <= step_d;
      drain_q <= drain_d;
    end
  end

  // Next-state logic and array control sequencing for the tile pass.
  always_comb begin
    state_d          = state_q;
    k_len_d          = k_len_q;
    step_d           = step_q;
    drain_d          = drain_q;
    in_ready_o       = 1'b0;
    arr_enable_o     = 1'b0;
    clear_acc_o      = 1'b0;
    compute_enable_o = 1'b0;
    done_o           = 1'b0;
    transfer         = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          k_len_d = k_len_i;
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        arr_enable_o = 1'b1;
        clear_acc_o  = 1'b1;
        step_d       = '0;
        drain_d      = '0;
        state_d      = (k_len_q != '0) ? S_FEED : S_DONE;
      end
      S_FEED: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          transfer         = 1'b1;
          arr_enable_o     = 1'b1;
          compute_enable_o = 1'b1;
          step_d           = step_q + K_BITS'(1);
          // Compare against k_len-1 so a full-scale k_len never needs the
          // counter to reach 2^K_BITS.
          if (step_q == (k_len_q - K_BITS'(1))) begin
            state_d = (DRAIN_CYCLES > 0) ? S_DRAIN : S_DONE;
          end
        end
      end
      S_DRAIN: begin
        arr_enable_o     = 1'b1;
        compute_enable_o = 1'b1;
        drain_d          = drain_q + DRAIN_BITS'(1);
        if (drain_q == DRAIN_LAST) begin
          drain_d = '0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy_o = (state_q != S_IDLE);

  // Per-lane skew: lane i delays its injected element by i advancing cycles.
  for (genvar i = 0; i < ARRAY_SIZE; i++) begin : g_lane
    logic [DATA_BITS-1:0] a_inj;
    logic [DATA_BITS-1:0] b_inj;

    // Only real transfers inject data; CLEAR and DRAIN push zeros.
    assign a_inj = transfer ? a_vec_i[i*DATA_BITS +: DATA_BITS] : '0;
    assign b_inj = transfer ? b_vec_i[i*DATA_BITS +: DATA_BITS] : '0;

    if (i == 0) begin : g_direct
      assign a_inputs_o[0 +: DATA_BITS] = a_inj;
      assign b_inputs_o[0 +: DATA_BITS] = b_inj;
    end else begin : g_pipe
      logic [DATA_BITS-1:0] a_pipe_q [0:i-1];
      logic [DATA_BITS-1:0] b_pipe_q [0:i-1];

      // i-stage shift register that only moves when the array advances.
      always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
          for (int s = 0; s < i; s++) begin
            a_pipe_q[s] <= '0;
            b_pipe_q[s] <= '0;
          end
        end else if (arr_enable_o) begin
          a_pipe_q[0] <= a_inj;
          b_pipe_q[0] <= b_inj;
          for (int s = 1; s < i; s++) begin
            a_pipe_q[s] <= a_pipe_q[s-1];
            b_pipe_q[s] <= b_pipe_q[s-1];
          end
        end
      end

      assign a_inputs_o[i*DATA_BITS +: DATA_BITS] = a_pipe_q[i-1];
      assign b_inputs_o[i*DATA_BITS +: DATA_BITS] = b_pipe_q[i-1];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_systolic_operand_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_systolic_operand_feeder
// Purpose  : Randomised bench for systolic_operand_feeder with a behavioural
//            reference model checked every cycle, plus literal timing checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_systolic_operand_feeder;

  localparam int DB  = 16;
  localparam int N   = 8;
  localparam int KB  = 8;
  localparam int W   = N * DB;
  localparam int DRN = 2 * (N - 1);

  localparam int M_IDLE  = 0;
  localparam int M_CLEAR = 1;
  localparam int M_FEED  = 2;
  localparam int M_DRAIN = 3;
  localparam int M_DONE  = 4;

  logic          clk = 1'b0;
  logic          reset_i = 1'b0;
  logic          start_i = 1'b0;
  logic [KB-1:0] k_len_i = '0;
  logic          in_valid_i = 1'b0;
  logic [W-1:0]  a_vec_i = '0;
  logic [W-1:0]  b_vec_i = '0;
  logic          in_ready_o, arr_enable_o, clear_acc_o, compute_enable_o;
  logic          busy_o, done_o;
  logic [W-1:0]  a_inputs_o, b_inputs_o;

  systolic_operand_feeder #(.DATA_BITS(DB), .ARRAY_SIZE(N), .K_BITS(KB)) dut (
    .clk_i(clk), .reset_i(reset_i), .start_i(start_i), .k_len_i(k_len_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .a_vec_i(a_vec_i), .b_vec_i(b_vec_i),
    .arr_enable_o(arr_enable_o), .clear_acc_o(clear_acc_o),
    .compute_enable_o(compute_enable_o),
    .a_inputs_o(a_inputs_o), .b_inputs_o(b_inputs_o),
    .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // hist[j] is the vector injected j+1 advances ago; lane i shows hist[i-1] lane i.
  int           m_phase = M_IDLE;
  int           m_k, m_cnt, m_dcnt;
  logic [W-1:0] ha [N];
  logic [W-1:0] hb [N];
  bit           armed = 1'b0;

  logic         x_xfer, x_en;
  logic [W-1:0] inja, injb, expa, expb;

  always @(negedge clk) begin
    if (reset_i) begin
      armed   = 1'b1;
      m_phase = M_IDLE;
      m_k = 0; m_cnt = 0; m_dcnt = 0;
      for (int j = 0; j < N; j++) begin ha[j] = '0; hb[j] = '0; end
      chk("rst_in_ready", in_ready_o, 0);
      chk("rst_arr_enable", arr_enable_o, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_done", done_o, 0);
      chk("rst_a_inputs", a_inputs_o, 0);
      chk("rst_b_inputs", b_inputs_o, 0);
    end else if (armed) begin
      x_xfer = (m_phase == M_FEED) && in_valid_i;
      x_en   = (m_phase == M_CLEAR) || x_xfer || (m_phase == M_DRAIN);
      inja   = x_xfer ? a_vec_i : '0;
      injb   = x_xfer ? b_vec_i : '0;
      for (int i = 0; i < N; i++) begin
        expa[i*DB +: DB] = (i == 0) ? inja[DB-1:0] : ha[i-1][i*DB +: DB];
        expb[i*DB +: DB] = (i == 0) ? injb[DB-1:0] : hb[i-1][i*DB +: DB];
      end
      chk("in_ready", in_ready_o, (m_phase == M_FEED));
      chk("arr_enable", arr_enable_o, x_en);
      chk("clear_acc", clear_acc_o, (m_phase == M_CLEAR));
      chk("compute_enable", compute_enable_o, x_xfer || (m_phase == M_DRAIN));
      chk("busy", busy_o, (m_phase != M_IDLE));
      chk("done", done_o, (m_phase == M_DONE));
      chk("a_inputs", a_inputs_o, expa);
      chk("b_inputs", b_inputs_o, expb);
      // advance the model to what the next clock edge produces
      if (x_en) begin
        for (int j = N - 1; j > 0; j--) begin ha[j] = ha[j-1]; hb[j] = hb[j-1]; end
        ha[0] = inja;
        hb[0] = injb;
      end
      case (m_phase)
        M_IDLE:  if (start_i) begin m_k = int'(k_len_i); m_phase = M_CLEAR; end
        M_CLEAR: begin m_cnt = 0; m_dcnt = 0; m_phase = (m_k != 0) ? M_FEED : M_DONE; end
        M_FEED:  if (x_xfer) begin
                   m_cnt++;
                   if (m_cnt == m_k) m_phase = M_DRAIN;
                 end
        M_DRAIN: begin m_dcnt++; if (m_dcnt == DRN) m_phase = M_DONE; end
        default: m_phase = M_IDLE;
      endcase
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] rand_vec();
    logic [W-1:0] v;
    for (int i = 0; i < N; i++) v[i*DB +: DB] = DB'($urandom);
    return v;
  endfunction

  function automatic logic [W-1:0] ramp_vec();
    logic [W-1:0] v;
    for (int i = 0; i < N; i++) v[i*DB +: DB] = DB'(16'h0100 * (i + 1));
    return v;
  endfunction

  // Runs one pass from the current cycle (cycle 0 = start cycle).
  // exp_done < 0 skips the literal latency check; stall_from > 0 drops
  // in_valid on cycles stall_from..stall_to.
  task automatic run_pass(input int k, input int stall_from, input int stall_to,
                          input int exp_done, input bit rnd, input bit ramp);
    int cyc;
    bit seen;
    logic [DB-1:0] lane3;
    k_len_i    = k[KB-1:0];
    start_i    = 1'b1;
    in_valid_i = 1'b1;
    a_vec_i    = ramp ? ramp_vec() : rand_vec();
    b_vec_i    = rand_vec();
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 1000) begin
      tick();
      cyc++;
      start_i = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      if (rnd) in_valid_i = ($urandom_range(0, 3) != 0);
      else     in_valid_i = !(stall_from > 0 && cyc >= stall_from && cyc <= stall_to);
      a_vec_i = ramp ? ramp_vec() : rand_vec();
      b_vec_i = rand_vec();
      #1;
      lane3 = a_inputs_o[3*DB +: DB];
      if (ramp && cyc == 4) chk("a_lane3_cycle4", lane3, 16'h0000);
      if (ramp && cyc == 5) chk("a_lane3_cycle5", lane3, 16'h0400);
      if (stall_from > 0 && cyc == stall_from) chk("stall_arr_enable", arr_enable_o, 0);
      if (done_o) begin
        seen = 1'b1;
        if (exp_done >= 0) chk("done_cycle", cyc, exp_done);
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done after %0d cycles expected done", cyc);
    end
    tick();
    start_i    = 1'b0;
    in_valid_i = 1'b0;
  endtask

  initial begin
    #3 reset_i = 1'b1;
    #1;
    chk("async_rst_busy", busy_o, 0);
    chk("async_rst_a_inputs", a_inputs_o, 0);
    tick();
    tick();
    reset_i = 1'b0;
    tick();

    run_pass(4, 0, -1, 20, 1'b0, 1'b1);            // basic 20-cycle pass
    run_pass(3, 3, 4, 21, 1'b0, 1'b0);             // 2-cycle stall
    run_pass(0, 0, -1, 2, 1'b0, 1'b0);             // empty pass
    for (int r = 0; r < 8; r++) begin
      run_pass($urandom_range(1, 20), 0, -1, -1, 1'b1, 1'b0);
      repeat ($urandom_range(0, 3)) tick();
    end
    run_pass(0, 0, -1, -1, 1'b1, 1'b0);

    // reset in the middle of DRAIN, then a fresh pass
    k_len_i    = 8'd4;
    start_i    = 1'b1;
    in_valid_i = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      start_i = 1'b0;
      a_vec_i = rand_vec();
    end
    #2 reset_i = 1'b1;
    #1;
    chk("drain_rst_busy", busy_o, 0);
    chk("drain_rst_arr_enable", arr_enable_o, 0);
    chk("drain_rst_a_inputs", a_inputs_o, 0);
    chk("drain_rst_done", done_o, 0);
    tick();
    reset_i    = 1'b0;
    in_valid_i = 1'b0;
    tick();
    run_pass(4, 0, -1, 20, 1'b0, 1'b1);

    run_pass(255, 0, -1, 2 + 255 + DRN, 1'b0, 1'b0);  // full-scale k_len
    repeat (4) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
